// File: rtl/sseg_decoder.sv
// Seven-segment bus receiver: qualifies multiplexed {an,sseg} samples,
// decodes each digit back to hex/dash/error and reports changes.
module sseg_decoder #(
    parameter int DIGITS        = 4,
    parameter int DIG_W         = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            sseg,
    input  logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   hex_out,
    output logic [DIGITS-1:0]     n_valid_out,
    output logic [DIGITS-1:0]     err_out,
    output logic                  upd_valid,
    input  logic                  upd_ready,
    output logic [DIG_W-1:0]      upd_digit,
    output logic [3:0]            upd_hex,
    output logic                  upd_n_valid,
    output logic                  upd_err,
    output logic                  upd_ovf
);

    localparam int SMP_W = DIGITS + 7;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 2);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES + 1);

    localparam logic [DIGITS-1:0] AN_ONE = DIGITS'(1);

    // Input sample and stability counter
    logic [SMP_W-1:0]  smp_q, smp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Registered views of the sample
    logic [DIGITS-1:0] an_r;
    logic [6:0]        seg_r;

    // Qualification
    logic              an_onehot;
    logic              accept;
    logic [DIG_W-1:0]  idx;

    // Decoder results
    logic [3:0]        dec_hex;
    logic              dec_nv;
    logic              dec_err;

    // Per-digit state
    logic [DIGITS-1:0][3:0] hex_q, hex_d;
    logic [DIGITS-1:0]      nv_q, nv_d;
    logic [DIGITS-1:0]      err_q, err_d;
    logic [DIGITS-1:0]      seen_q, seen_d;

    // Change detection
    logic [5:0]        cur_val;
    logic [5:0]        new_val;
    logic              evt;

    // Pending update slot
    logic              pv_q, pv_d;
    logic [DIG_W-1:0]  pdig_q, pdig_d;
    logic [3:0]        phex_q, phex_d;
    logic              pnv_q, pnv_d;
    logic              perr_q, perr_d;
    logic              ovf_q, ovf_d;

    assign an_r  = smp_q[SMP_W-1:7];
    assign seg_r = smp_q[6:0];

    // Next sample and run length of identical samples
    always_comb begin
        smp_d = {an, sseg};
        cnt_d = cnt_q;
        if (smp_d != smp_q) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Blank or multi-hot enables never qualify
    always_comb begin
        an_onehot = (an_r != '0) && ((an_r & (an_r - AN_ONE)) == '0);
        accept    = an_onehot && (cnt_q == CNT_ACC);
    end

    // Position of the active enable bit
    always_comb begin
        idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (an_r[i]) begin
                idx = DIG_W'(i);
            end
        end
    end

    // Segment pattern back to nibble, dash or error
    always_comb begin
        dec_hex = 4'h0;
        dec_nv  = 1'b0;
        dec_err = 1'b0;
        case (seg_r)
            7'h3F: dec_hex = 4'h0;
            7'h06: dec_hex = 4'h1;
            7'h5B: dec_hex = 4'h2;
            7'h4F: dec_hex = 4'h3;
            7'h66: dec_hex = 4'h4;
            7'h6D: dec_hex = 4'h5;
            7'h7D: dec_hex = 4'h6;
            7'h07: dec_hex = 4'h7;
            7'h7F: dec_hex = 4'h8;
            7'h67: dec_hex = 4'h9;
            7'h77: dec_hex = 4'hA;
            7'h7C: dec_hex = 4'hB;
            7'h39: dec_hex = 4'hC;
            7'h5E: dec_hex = 4'hD;
            7'h79: dec_hex = 4'hE;
            7'h71: dec_hex = 4'hF;
            7'h40: dec_nv  = 1'b1;
            default: dec_err = 1'b1;
        endcase
    end

    // An event fires on first sight of a digit or when its value changes
    always_comb begin
        cur_val = {hex_q[idx], nv_q[idx], err_q[idx]};
        new_val = {dec_hex, dec_nv, dec_err};
        evt     = accept && (!seen_q[idx] || (cur_val != new_val));
    end

    // Commit the decoded value into the addressed digit
    always_comb begin
        hex_d  = hex_q;
        nv_d   = nv_q;
        err_d  = err_q;
        seen_d = seen_q;
        if (accept) begin
            hex_d[idx]  = dec_hex;
            nv_d[idx]   = dec_nv;
            err_d[idx]  = dec_err;
            seen_d[idx] = 1'b1;
        end
    end

    // Single-entry slot: newest event wins, unconsumed loss is sticky
    always_comb begin
        pv_d   = pv_q;
        pdig_d = pdig_q;
        phex_d = phex_q;
        pnv_d  = pnv_q;
        perr_d = perr_q;
        ovf_d  = ovf_q;
        if (evt) begin
            pv_d   = 1'b1;
            pdig_d = idx;
            phex_d = dec_hex;
            pnv_d  = dec_nv;
            perr_d = dec_err;
            if (pv_q && !upd_ready) begin
                ovf_d = 1'b1;
            end
        end else if (pv_q && upd_ready) begin
            pv_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            smp_q  <= '0;
            cnt_q  <= '0;
            hex_q  <= '0;
            nv_q   <= '0;
            err_q  <= '0;
            seen_q <= '0;
            pv_q   <= 1'b0;
            pdig_q <= '0;
            phex_q <= '0;
            pnv_q  <= 1'b0;
            perr_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            smp_q  <= smp_d;
            cnt_q  <= cnt_d;
            hex_q  <= hex_d;
            nv_q   <= nv_d;
            err_q  <= err_d;
            seen_q <= seen_d;
            pv_q   <= pv_d;
            pdig_q <= pdig_d;
            phex_q <= phex_d;
            pnv_q  <= pnv_d;
            perr_q <= perr_d;
            ovf_q  <= ovf_d;
        end
    end

    assign hex_out     = hex_q;
    assign n_valid_out = nv_q;
    assign err_out     = err_q;
    assign upd_valid   = pv_q;
    assign upd_digit   = pdig_q;
    assign upd_hex     = phex_q;
    assign upd_n_valid = pnv_q;
    assign upd_err     = perr_q;
    assign upd_ovf     = ovf_q;

endmodule

// File: tb/tb_sseg_decoder.sv
// Scoreboard bench for sseg_decoder: expected update events are queued
// as stimulus is applied and matched when the handshake completes.
module tb_sseg_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  sseg;
    logic [3:0]  an;
    logic [15:0] hex_out;
    logic [3:0]  n_valid_out;
    logic [3:0]  err_out;
    logic        upd_valid;
    logic        upd_ready;
    logic [1:0]  upd_digit;
    logic [3:0]  upd_hex;
    logic        upd_n_valid;
    logic        upd_err;
    logic        upd_ovf;

    int n_chk  = 0;
    int n_fail = 0;
    int n_evt  = 0;
    int evt0;

    logic [7:0] exp_q[$];
    logic [6:0] seg_tbl [4];

    sseg_decoder #(
        .DIGITS(4),
        .DIG_W(2),
        .STABLE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sseg(sseg),
        .an(an),
        .hex_out(hex_out),
        .n_valid_out(n_valid_out),
        .err_out(err_out),
        .upd_valid(upd_valid),
        .upd_ready(upd_ready),
        .upd_digit(upd_digit),
        .upd_hex(upd_hex),
        .upd_n_valid(upd_n_valid),
        .upd_err(upd_err),
        .upd_ovf(upd_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ev(input int d, input int h,
                                      input bit nv, input bit er);
        return {2'(d), 4'(h), nv, er};
    endfunction

    // Inputs change at posedge+1, so negedge values hold through the next edge
    always @(negedge clk) begin
        if (upd_valid === 1'b1 && upd_ready === 1'b1) begin
            n_evt++;
            if (exp_q.size() == 0) begin
                chk("evt_unexpected", 32'(1), 32'(0));
            end else begin
                chk("evt", 32'({upd_digit, upd_hex, upd_n_valid, upd_err}),
                    32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        an   = 4'b0000;
        sseg = 7'h00;
        tick(2);
        rst  = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        an        = 4'b0000;
        sseg      = 7'h00;
        upd_ready = 1'b0;
        seg_tbl   = '{7'h3F, 7'h06, 7'h5B, 7'h4F};

        // Reset state and basic latency
        do_reset();
        chk("rst_hex", 32'(hex_out), 32'(0));
        chk("rst_nv", 32'(n_valid_out), 32'(0));
        chk("rst_err", 32'(err_out), 32'(0));
        chk("rst_valid", 32'(upd_valid), 32'(0));
        chk("rst_ovf", 32'(upd_ovf), 32'(0));
        upd_ready = 1'b1;
        an        = 4'b0001;
        sseg      = 7'h5B;
        exp_q.push_back(ev(0, 2, 0, 0));
        tick(4);
        chk("t1_early_hex", 32'(hex_out), 32'(0));
        chk("t1_early_valid", 32'(upd_valid), 32'(0));
        tick(1);
        chk("t1_hex", 32'(hex_out), 32'h0002);
        chk("t1_valid", 32'(upd_valid), 32'(1));
        tick(1);
        chk("t1_one_cycle", 32'(upd_valid), 32'(0));
        tick(2);
        chk("t1_sb_empty", 32'(exp_q.size()), 32'(0));

        // Glitch rejection
        do_reset();
        evt0 = n_evt;
        an   = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            sseg = k[0] ? 7'h06 : 7'h7F;
            tick(2);
        end
        chk("t2_hex", 32'(hex_out), 32'(0));
        chk("t2_valid", 32'(upd_valid), 32'(0));
        chk("t2_ovf", 32'(upd_ovf), 32'(0));
        chk("t2_events", 32'(n_evt - evt0), 32'(0));

        // Dash then error on digit 2
        do_reset();
        evt0 = n_evt;
        an   = 4'b0100;
        sseg = 7'h40;
        exp_q.push_back(ev(2, 0, 1, 0));
        tick(6);
        chk("t3_dash_nv", 32'(n_valid_out), 32'b0100);
        chk("t3_dash_hex", 32'(hex_out[11:8]), 32'(0));
        chk("t3_dash_err", 32'(err_out), 32'(0));
        sseg = 7'h55;
        exp_q.push_back(ev(2, 0, 0, 1));
        tick(6);
        chk("t3_err", 32'(err_out), 32'b0100);
        chk("t3_err_nv", 32'(n_valid_out), 32'(0));
        chk("t3_err_hex", 32'(hex_out), 32'(0));
        chk("t3_events", 32'(n_evt - evt0), 32'(2));

        // Refresh suppression over three scan rounds
        do_reset();
        evt0 = n_evt;
        for (int r = 0; r < 3; r++) begin
            for (int d = 0; d < 4; d++) begin
                an   = 4'(1 << d);
                sseg = seg_tbl[d];
                if (r == 0) exp_q.push_back(ev(d, d, 0, 0));
                tick(6);
            end
        end
        chk("t4_hex", 32'(hex_out), 32'h3210);
        chk("t4_events", 32'(n_evt - evt0), 32'(4));
        chk("t4_sb_empty", 32'(exp_q.size()), 32'(0));

        // Backpressure and overflow
        do_reset();
        upd_ready = 1'b0;
        an        = 4'b0001;
        sseg      = 7'h06;
        tick(6);
        chk("t5_first_valid", 32'(upd_valid), 32'(1));
        chk("t5_first_ovf", 32'(upd_ovf), 32'(0));
        an   = 4'b0010;
        sseg = 7'h07;
        tick(6);
        chk("t5_ovf", 32'(upd_ovf), 32'(1));
        chk("t5_valid", 32'(upd_valid), 32'(1));
        chk("t5_digit", 32'(upd_digit), 32'(1));
        chk("t5_hex", 32'(upd_hex), 32'(7));
        chk("t5_hex_out", 32'(hex_out), 32'h0071);
        exp_q.push_back(ev(1, 7, 0, 0));
        upd_ready = 1'b1;
        tick(1);
        upd_ready = 1'b0;
        chk("t5_drained", 32'(upd_valid), 32'(0));
        chk("t5_ovf_sticky", 32'(upd_ovf), 32'(1));
        chk("t5_sb_empty", 32'(exp_q.size()), 32'(0));

        // Multi-hot rejection and reset mid-qualification
        do_reset();
        evt0      = n_evt;
        upd_ready = 1'b1;
        an        = 4'b0011;
        sseg      = 7'h3F;
        tick(10);
        chk("t6_mh_hex", 32'(hex_out), 32'(0));
        chk("t6_mh_valid", 32'(upd_valid), 32'(0));
        chk("t6_mh_events", 32'(n_evt - evt0), 32'(0));
        upd_ready = 1'b0;
        an        = 4'b0010;
        sseg      = 7'h6D;
        tick(6);
        chk("t6_pre_hex", 32'(hex_out), 32'h0050);
        chk("t6_pre_valid", 32'(upd_valid), 32'(1));
        an   = 4'b0001;
        sseg = 7'h66;
        tick(3);
        rst = 1'b1;
        tick(1);
        chk("t6_rst_hex", 32'(hex_out), 32'(0));
        chk("t6_rst_valid", 32'(upd_valid), 32'(0));
        chk("t6_rst_digit", 32'(upd_digit), 32'(0));
        chk("t6_rst_uhex", 32'(upd_hex), 32'(0));
        chk("t6_rst_ovf", 32'(upd_ovf), 32'(0));
        rst       = 1'b0;
        upd_ready = 1'b1;
        exp_q.push_back(ev(0, 4, 0, 0));
        tick(4);
        chk("t6_relat_hex", 32'(hex_out), 32'(0));
        tick(1);
        chk("t6_hex", 32'(hex_out), 32'h0004);
        tick(2);
        chk("t6_sb_empty", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sseg_decoder.md
Name: sseg_decoder

Overview:
Receive-side counterpart of the hex-to-seven-segment driver. It samples a multiplexed seven-segment bus (segment lines plus one-hot digit enables) and filters out glitches and scan transitions. Each digit is decoded back into a hex nibble, a "-" (invalid-input) flag or an error flag. Per-digit state is held in registers, and changes are reported through a single-entry valid/ready update port for console readback and self-check logic.

Parameters:
DIGITS, 4, number of multiplexed digits; the width of an.
DIG_W, 2, width of the digit index; equals clog2(DIGITS).
STABLE_CYCLES, 4, number of consecutive identical registered samples needed to accept a pattern; must be 1 or more.

Ports:
clk  input  1  system clock; every register updates on the rising edge.
rst  input  1  synchronous, active-high reset.
sseg  input  7  segment lines, active-high; bit0=a through bit6=g.
an  input  DIGITS  digit enable, active-high, one-hot when valid.
hex_out  output  4*DIGITS  decoded nibble per digit; digit i occupies bits [4i+3:4i].
n_valid_out  output  DIGITS  per-digit "-" indicator.
err_out  output  DIGITS  per-digit unrecognised-pattern flag.
upd_valid  output  1  an update event is pending.
upd_ready  input  1  consumer accepts the pending event.
upd_digit  output  DIG_W  digit index of the pending event.
upd_hex  output  4  nibble of the pending event.
upd_n_valid  output  1  "-" flag of the pending event.
upd_err  output  1  error flag of the pending event.
upd_ovf  output  1  sticky flag: a pending event was overwritten.

Behaviour:
- Reset (rst=1 at an edge): all outputs go to 0. The input register, stability counter, per-digit seen bits and pending slot all clear. rst overrides any activity in progress.
- Input stage: {an,sseg} is registered once; all further logic uses the registered copy.
- Stability counter:
  - If the new registered sample differs from the previous one, the counter loads 1.
  - If it is the same, the counter increments and saturates at STABLE_CYCLES+1.
  - An accept pulse fires exactly once, in the cycle the counter equals STABLE_CYCLES.
- Blanking: if the registered an is zero or not one-hot, no accept fires, even when the counter reaches STABLE_CYCLES.
- Decode table (sseg hex value to result):
  - 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 67=9, 77=A, 7C=b, 39=C, 5E=d, 79=E, 71=F.
  - 40 gives n_valid=1, hex=0.
  - Any other pattern gives err=1, hex=0.
  - n_valid and err are never set together.
- Commit: on the edge after accept, the digit index i is taken from the position of the set an bit. hex_out[i], n_valid_out[i] and err_out[i] load the decoded result, and seen[i] sets.
- Latency: if {an,sseg} is set before edge 1 and held, the sample registers at edge 1. The digit outputs and any event become visible after edge STABLE_CYCLES+1, which is edge 5 at the default.
- Event generation: an event is produced at commit only when seen[i] was 0 or the stored {hex,n_valid,err} differs from the new value. Repeated refresh of the same value produces no event.
- Update port:
  - An event loads the pending slot and sets upd_valid.
  - upd_valid and the upd_* fields hold stable until a cycle where upd_valid & upd_ready; that edge clears upd_valid.
- Simultaneous events:
  - New event while pending and upd_ready=0: the slot is overwritten with the new event, upd_valid stays 1, and upd_ovf sets. upd_ovf is cleared only by rst.
  - New event in the same cycle as upd_valid & upd_ready: the old event is consumed, the new one loads, and there is no overflow.
- Mid-window change: any change in an or sseg restarts qualification at count 1. Digit registers keep their prior values.

Test Plan:
- Reset, then an=0001, sseg=5B held for 8 cycles with upd_ready=1 -> after edge 5: hex_out[3:0]=2, upd_valid=1 for exactly one cycle, upd_digit=0, upd_hex=2, upd_n_valid=0, upd_err=0.
- Glitch rejection: an=0010 with sseg alternating 7F/06 every 2 cycles for 20 cycles -> no commit; hex_out, upd_valid and upd_ovf stay 0.
- Dash and error: an=0100 with sseg=40 held for 6 cycles -> n_valid_out[2]=1, hex_out[11:8]=0. Then sseg=55 held for 6 cycles -> err_out[2]=1, n_valid_out[2]=0, and a second event is issued.
- Refresh suppression: scan digits 0..3 with 3F/06/5B/4F, 6 cycles per digit, for 3 full rounds -> exactly 4 events in total; hex_out=16'h3210.
- Backpressure: upd_ready=0 while digit 0 commits 1 and then digit 1 commits 7 -> upd_ovf=1, pending event shows upd_digit=1, upd_hex=7. Raising upd_ready for one cycle -> upd_valid=0.
- Multi-hot and reset: an=0011 held 10 cycles -> no commit. Then rst asserted mid-qualification of a valid pattern -> all outputs 0 on the following edge, and the pattern needs the full 5-edge latency again after rst drops.
